// File: rtl/tile_pkg.sv
// Shared constants, tile ids and types for the scanline tile fetch scheduler.
package tile_pkg;
  localparam int TILE_PX   = 16;
  localparam int MAP_COLS  = 40;
  localparam int MAP_ROWS  = 30;
  localparam int TILE_ID_W = 4;
  localparam int MAP_AW    = 11;

  localparam logic [9:0] VIS_LINES  = 10'(MAP_ROWS * TILE_PX);
  localparam logic [9:0] VIS_PIXELS = 10'(MAP_COLS * TILE_PX);
  localparam logic [5:0] LAST_COL   = 6'(MAP_COLS - 1);

  localparam logic [TILE_ID_W-1:0] FLOOR       = 4'd0;
  localparam logic [TILE_ID_W-1:0] WALL        = 4'd1;
  localparam logic [TILE_ID_W-1:0] RED_DOOR    = 4'd2;
  localparam logic [TILE_ID_W-1:0] BLUE_DOOR   = 4'd3;
  localparam logic [TILE_ID_W-1:0] LAVA        = 4'd4;
  localparam logic [TILE_ID_W-1:0] WATER       = 4'd5;
  localparam logic [TILE_ID_W-1:0] PLATE       = 4'd6;
  localparam logic [TILE_ID_W-1:0] PUZZLE_DOOR = 4'd7;
  localparam logic [TILE_ID_W-1:0] BG          = 4'd8;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic [TILE_ID_W-1:0] id;
    logic [7:0]           row;
  } lbuf_entry_t;

  // r*40 as (r<<5)+(r<<3) so no multiplier is inferred.
  function automatic logic [MAP_AW-1:0] map_row_base(input logic [4:0] r);
    return ({6'd0, r} << 5) + ({6'd0, r} << 3);
  endfunction

  function automatic logic is_anim_tile(input logic [TILE_ID_W-1:0] id);
    return (id == LAVA) || (id == WATER);
  endfunction
endpackage

// File: rtl/tile_fetch_sched_if.sv
// Tile-map RAM and tile ROM port bundle driven by the fetch scheduler.
interface tile_fetch_sched_if;
  import tile_pkg::*;

  logic [MAP_AW-1:0]    map_addr;
  logic [TILE_ID_W-1:0] map_data;
  logic [7:0]           rom_addr;
  logic [7:0]           rom_data;

  // Map RAM returns map_data one cycle after map_addr; ROM is combinational.
  modport master (output map_addr, rom_addr, input map_data, rom_data);
  modport slave  (input map_addr, rom_addr, output map_data, rom_data);
endinterface

// File: rtl/tile_line_buf.sv
// Two-bank x 40-entry line buffer: one synchronous write port, one registered
// pixel/id read port; contents cleared synchronously on Reset.
module tile_line_buf
  import tile_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 i_wr_en,
  input  logic                 i_wr_bank,
  input  logic [5:0]           i_wr_col,
  input  lbuf_entry_t          i_wr_data,
  input  logic                 i_rd_en,
  input  logic                 i_rd_bank,
  input  logic [5:0]           i_rd_col,
  input  logic [2:0]           i_rd_bit,
  output logic                 o_rd_pix,
  output logic [TILE_ID_W-1:0] o_rd_id
);
  lbuf_entry_t r_mem [2][MAP_COLS];
  lbuf_entry_t w_rd_entry;

  assign w_rd_entry = r_mem[i_rd_bank][i_rd_col];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < MAP_COLS; c++) begin
          r_mem[b][c] <= '0;
        end
      end
      o_rd_pix <= 1'b0;
      o_rd_id  <= '0;
    end else begin
      if (i_wr_en) begin
        r_mem[i_wr_bank][i_wr_col] <= i_wr_data;
      end
      if (i_rd_en) begin
        o_rd_pix <= w_rd_entry.row[i_rd_bit];
        o_rd_id  <= w_rd_entry.id;
      end else begin
        o_rd_pix <= 1'b0;
        o_rd_id  <= '0;
      end
    end
  end
endmodule

// File: rtl/tile_fetch_sched.sv
// Scanline tile fetch scheduler: fills the hidden line-buffer bank during hblank and
// serves pixel bits from the visible bank. TILE_FETCH_ANIM_EN enables lava/water row scrolling.
module tile_fetch_sched
  import tile_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 line_start,
  input  logic [9:0]           line_y,
  tile_fetch_sched_if.master   mem,
  input  logic [9:0]           DrawX,
  output logic                 pix_on,
  output logic [TILE_ID_W-1:0] pix_tile,
  output logic                 busy,
  output logic                 overrun,
  output state_t               o_dbg_state
);
  state_t            r_state;
  logic              r_busy;
  logic              r_overrun;
  logic              r_disp_bank;
  logic [3:0]        r_row;
  logic [MAP_AW-1:0] r_map_base;
  logic [5:0]        r_col;
  logic [5:0]        r_wcol;
  logic              r_pend;

  logic [3:0]        w_row_eff;
  logic              w_abort;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [2:0]        w_rd_bit;
  lbuf_entry_t       w_wr_data;

`ifdef TILE_FETCH_ANIM_EN
  logic [5:0] r_frame_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_cnt <= '0;
    end else if (line_start && (line_y == 10'd0)) begin
      r_frame_cnt <= r_frame_cnt + 6'd1;
    end
  end

  assign w_row_eff = is_anim_tile(mem.map_data) ? (r_row + {1'b0, r_frame_cnt[5:3]}) : r_row;
`else
  assign w_row_eff = r_row;
`endif

  // r_pend marks a column whose tile id is on map_data this cycle and is written now.
  assign w_abort      = line_start && (r_state == FETCH);
  assign w_wr_en      = r_pend && !w_abort;
  assign w_wr_data    = {mem.map_data, mem.rom_data};
  assign mem.map_addr = (r_state == FETCH) ? (r_map_base + {5'd0, r_col}) : '0;
  assign mem.rom_addr = r_pend ? {mem.map_data, w_row_eff} : '0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_disp_bank <= 1'b0;
      r_row       <= '0;
      r_map_base  <= '0;
      r_col       <= '0;
      r_wcol      <= '0;
      r_pend      <= 1'b0;
    end else if (line_start) begin
      // A line_start during DRAIN still lets the column-39 write land (w_wr_en).
      r_disp_bank <= ~r_disp_bank;
      r_pend      <= 1'b0;
      r_col       <= '0;
      if (r_state == FETCH) begin
        r_overrun <= 1'b1;
      end
      if (line_y < VIS_LINES) begin
        r_row      <= line_y[3:0];
        r_map_base <= map_row_base(line_y[8:4]);
        r_state    <= FETCH;
        r_busy     <= 1'b1;
      end else begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end
    end else begin
      case (r_state)
        FETCH: begin
          r_pend <= 1'b1;
          r_wcol <= r_col;
          if (r_col == LAST_COL) begin
            r_state <= DRAIN;
          end else begin
            r_col <= r_col + 6'd1;
          end
        end
        DRAIN: begin
          r_pend  <= 1'b0;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_pend <= 1'b0;
        end
      endcase
    end
  end

  // Each ROM bit spans two pixels, MSB leftmost: bit = 7 - DrawX[3:1].
  assign w_rd_en  = DrawX < VIS_PIXELS;
  assign w_rd_bit = 3'((4'd15 - DrawX[3:0]) >> 1);

  tile_line_buf u_line_buf (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_wr_en   (w_wr_en),
    .i_wr_bank (~r_disp_bank),
    .i_wr_col  (r_wcol),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_bank (r_disp_bank),
    .i_rd_col  (DrawX[9:4]),
    .i_rd_bit  (w_rd_bit),
    .o_rd_pix  (pix_on),
    .o_rd_id   (pix_tile)
  );

  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_tile_fetch_sched.sv
// Bench for tile_fetch_sched: map RAM / ROM models, a line-level reference model of
// both buffer banks, and one task per scenario.
module tb_tile_fetch_sched;
  import tile_pkg::*;

  logic                 Clk = 1'b0;
  logic                 Reset = 1'b1;
  logic                 line_start = 1'b0;
  logic [9:0]           line_y = '0;
  logic [9:0]           DrawX = '0;
  logic                 pix_on;
  logic [TILE_ID_W-1:0] pix_tile;
  logic                 busy;
  logic                 overrun;
  state_t               dbg_state;

  tile_fetch_sched_if mem_if ();

  tile_fetch_sched dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .line_start  (line_start),
    .line_y      (line_y),
    .mem         (mem_if),
    .DrawX       (DrawX),
    .pix_on      (pix_on),
    .pix_tile    (pix_tile),
    .busy        (busy),
    .overrun     (overrun),
    .o_dbg_state (dbg_state)
  );

  // clock / memories
  always #5 Clk = ~Clk;

  logic [TILE_ID_W-1:0] map_mem [2048];
  logic [7:0]           rom_mem [256];
  logic [3:0]           tile_ids [9];

  always @(posedge Clk) mem_if.map_data <= map_mem[mem_if.map_addr];
  assign mem_if.rom_data = rom_mem[mem_if.rom_addr];

  // reference model and scoreboard
  int         n_vec = 0;
  int         n_err = 0;
  int         exp_disp = 0;
  int         exp_frame = 0;
  int         exp_id  [2][40];
  int         exp_row [2][40];
  logic [7:0] first_rom;
  logic [4:0] exp_q [$];

  function automatic int eff_row(input int id, input int row);
`ifdef TILE_FETCH_ANIM_EN
    if (id == int'(LAVA) || id == int'(WATER)) return (row + (exp_frame / 8) % 8) % 16;
`endif
    return row;
  endfunction

  function automatic logic [4:0] exp_pix(input int x);
    int c, b, r;
    if (x >= 640) return 5'd0;
    c = x / 16;
    b = 7 - (x % 16) / 2;
    r = exp_row[exp_disp][c];
    return {1'((r >> b) & 1), 4'(exp_id[exp_disp][c])};
  endfunction

  task automatic model_clear();
    exp_disp = 0;
    exp_frame = 0;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 40; c++) begin
        exp_id[b][c] = 0;
        exp_row[b][c] = 0;
      end
  endtask

  // line y lands fully in the hidden bank
  task automatic commit(input int y);
    int wb, base, row, id;
    wb = exp_disp ^ 1;
    base = (y / 16) * 40;
    row = y % 16;
    for (int c = 0; c < 40; c++) begin
      id = int'(map_mem[base + c]);
      exp_id[wb][c] = id;
      exp_row[wb][c] = int'(rom_mem[id * 16 + eff_row(id, row)]);
    end
  endtask

  // drivers: every task starts and ends at a falling edge
  task automatic start_line(input int y);
    line_start = 1'b1;
    line_y = 10'(y);
    @(negedge Clk);
    line_start = 1'b0;
    exp_disp ^= 1;
    if (y == 0) exp_frame = (exp_frame + 1) % 64;
  endtask

  task automatic run_fetch(input int y, input int ncyc);
    int base, row, id;
    logic [7:0] exp_rom;
    base = (y / 16) * 40;
    row = y % 16;
    for (int k = 0; k < ncyc; k++) begin
      n_vec++;
      if (busy !== 1'b1 || dbg_state !== ((k < 40) ? FETCH : DRAIN)) begin
        n_err++;
        $display("FAIL fetch_busy y=%0d k=%0d got busy=%b state=%0d", y, k, busy, dbg_state);
      end
      if (k < 40) begin
        n_vec++;
        if (mem_if.map_addr !== 11'(base + k)) begin
          n_err++;
          $display("FAIL map_addr y=%0d k=%0d got %0d want %0d", y, k, mem_if.map_addr, base + k);
        end
      end
      if (k >= 1) begin
        id = int'(map_mem[base + k - 1]);
        exp_rom = 8'(id * 16 + eff_row(id, row));
        n_vec++;
        if (mem_if.rom_addr !== exp_rom) begin
          n_err++;
          $display("FAIL rom_addr y=%0d k=%0d got %h want %h", y, k, mem_if.rom_addr, exp_rom);
        end
        if (k == 1) first_rom = mem_if.rom_addr;
      end
      @(negedge Clk);
    end
    if (ncyc == 41) begin
      n_vec++;
      if (busy !== 1'b0 || dbg_state !== IDLE || mem_if.map_addr !== '0 || mem_if.rom_addr !== '0) begin
        n_err++;
        $display("FAIL fetch_end y=%0d got busy=%b state=%0d map=%0d rom=%h want idle/0", y, busy,
                 dbg_state, mem_if.map_addr, mem_if.rom_addr);
      end
    end
  endtask

  task automatic do_line(input int y);
    start_line(y);
    if (y < 480) begin
      run_fetch(y, 41);
      commit(y);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (busy !== 1'b0 || dbg_state !== IDLE || mem_if.map_addr !== '0) begin
          n_err++;
          $display("FAIL offscreen_idle k=%0d got busy=%b state=%0d map=%0d", k, busy, dbg_state, mem_if.map_addr);
        end
        @(negedge Clk);
      end
    end
  endtask

  task automatic read_burst(input int n);
    logic [4:0] e;
    int x;
    for (int i = 0; i < n; i++) begin
      x = $urandom_range(0, 799);
      DrawX = 10'(x);
      exp_q.push_back(exp_pix(x));
      @(negedge Clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({pix_on, pix_tile} !== e) begin
        n_err++;
        $display("FAIL readout x=%0d got on=%b tile=%0d want on=%b tile=%0d", x, pix_on, pix_tile, e[4], e[3:0]);
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    n_vec++;
    if (busy !== 1'b0 || overrun !== 1'b0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_ctrl got busy=%b overrun=%b state=%0d want 0/0/IDLE", busy, overrun, dbg_state);
    end
    n_vec++;
    if (pix_on !== 1'b0 || pix_tile !== '0 || mem_if.map_addr !== '0 || mem_if.rom_addr !== '0) begin
      n_err++;
      $display("FAIL reset_out got on=%b tile=%0d map=%0d rom=%h want zeros", pix_on, pix_tile,
               mem_if.map_addr, mem_if.rom_addr);
    end
    Reset = 1'b0;
    model_clear();
    @(negedge Clk);
    read_burst(8);
  endtask

  task automatic test_map_fill();
    for (int a = 0; a < 1200; a++) map_mem[a] = tile_ids[(a % 40) % 9];
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
    do_line(0);
    do_line(16);
    DrawX = 10'd32;
    @(negedge Clk);
    n_vec++;
    if (pix_tile !== 4'd2 || pix_on !== 1'b1) begin
      n_err++;
      $display("FAIL map_fill_x32 got on=%b tile=%0d want on=1 tile=2", pix_on, pix_tile);
    end
    read_burst(40);
  endtask

  task automatic test_row_select();
    map_mem[40] = LAVA;
    do_line(21);
    n_vec++;
    if (first_rom !== 8'h45) begin
      n_err++;
      $display("FAIL row_select_rom got %h want 45", first_rom);
    end
  endtask

  task automatic test_offscreen();
    do_line(480);
    DrawX = 10'd0;
    @(negedge Clk);
    n_vec++;
    if (pix_on !== 1'b1 || pix_tile !== 4'd4) begin
      n_err++;
      $display("FAIL row_select_x0 got on=%b tile=%0d want on=1 tile=4", pix_on, pix_tile);
    end
    DrawX = 10'd700;
    @(negedge Clk);
    n_vec++;
    if (pix_on !== 1'b0 || pix_tile !== '0) begin
      n_err++;
      $display("FAIL offscreen_x700 got on=%b tile=%0d want 0/0", pix_on, pix_tile);
    end
    read_burst(30);
  endtask

  task automatic test_overrun();
    start_line(16);
    run_fetch(16, 19);
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_early got %b want 0", overrun);
    end
    start_line(32);
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set got %b want 1", overrun);
    end
    run_fetch(32, 41);
    commit(32);
    do_line(480);
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_sticky got %b want 1", overrun);
    end
    read_burst(30);
  endtask

  task automatic test_reset_mid_fetch();
    start_line(48);
    run_fetch(48, 10);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_clear();
    n_vec++;
    if (busy !== 1'b0 || dbg_state !== IDLE || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_ctrl got busy=%b state=%0d overrun=%b want 0/IDLE/0", busy, dbg_state, overrun);
    end
    n_vec++;
    if (mem_if.map_addr !== '0 || mem_if.rom_addr !== '0 || pix_on !== 1'b0 || pix_tile !== '0) begin
      n_err++;
      $display("FAIL midreset_out got map=%0d rom=%h on=%b tile=%0d want zeros", mem_if.map_addr,
               mem_if.rom_addr, pix_on, pix_tile);
    end
    read_burst(20);
  endtask

  task automatic test_back_to_back();
    start_line(100);
    run_fetch(100, 40);
    commit(100);
    start_line(200);
    run_fetch(200, 41);
    commit(200);
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL drain_overlap_overrun got %b want 0", overrun);
    end
    read_burst(30);
  endtask

  task automatic test_anim();
    logic [7:0] want;
`ifdef TILE_FETCH_ANIM_EN
    want = 8'h41;
`else
    want = 8'h40;
`endif
    map_mem[0] = LAVA;
    for (int i = 0; i < 8; i++) do_line(0);
    n_vec++;
    if (first_rom !== want) begin
      n_err++;
      $display("FAIL anim_rom got %h want %h", first_rom, want);
    end
    do_line(480);
    read_burst(30);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < 1200; a++) map_mem[a] = 4'($urandom_range(0, 15));
      for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom_range(0, 255));
      do_line($urandom_range(0, 519));
      read_burst(40);
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) map_mem[a] = '0;
    for (int i = 0; i < 256; i++) rom_mem[i] = '0;
    tile_ids = '{FLOOR, WALL, RED_DOOR, BLUE_DOOR, LAVA, WATER, PLATE, PUZZLE_DOOR, BG};
    @(negedge Clk);
    test_reset();
    test_map_fill();
    test_row_select();
    test_offscreen();
    test_overrun();
    test_reset_mid_fetch();
    test_back_to_back();
    test_anim();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached after %0d vectors", n_vec);
    $fatal(1, "time limit");
  end
endmodule
